// File: rtl/tsetlin_pkg.sv
// Shared definitions for the Tsetlin feedback environment.
//   LFSR_W / LFSR_MASK : 16-bit Galois LFSR geometry (maximal period 65535)
//   fb_state_t         : environment FSM encodings (IDLE/RUN/REPORT, 2 bits)
//   FB_PENALTY/REWARD  : polarity of the feedback bit B
//   lfsr_step          : one Galois shift of the LFSR
package tsetlin_pkg;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    FB_IDLE   = 2'd0,
    FB_RUN    = 2'd1,
    FB_REPORT = 2'd2
  } fb_state_t;

  localparam logic FB_PENALTY = 1'b1;
  localparam logic FB_REWARD  = 1'b0;

  // Right-shifting Galois form: the bit shifted out is fed back through the mask.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/tsetlin_env_feedback_if.sv
// Handshake bundle between the automaton-side integrator and the feedback
// environment.
//   master : drives start/win/a_in/p0_thr/p1_thr (and seed_ld/seed_val)
//   slave  : drives b/b_vld/busy/done/pen_cnt/a1_cnt
// Optional seed-load signals exist only when TSETLIN_FB_SEED_LOAD_EN is defined.
interface tsetlin_env_feedback_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] win;
  logic             a_in;
  logic [15:0]      p0_thr;
  logic [15:0]      p1_thr;
  logic             b;
  logic             b_vld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pen_cnt;
  logic [CNT_W-1:0] a1_cnt;
`ifdef TSETLIN_FB_SEED_LOAD_EN
  logic             seed_ld;
  logic [15:0]      seed_val;

  modport master (
    output start, win, a_in, p0_thr, p1_thr, seed_ld, seed_val,
    input  b, b_vld, busy, done, pen_cnt, a1_cnt
  );
  modport slave (
    input  start, win, a_in, p0_thr, p1_thr, seed_ld, seed_val,
    output b, b_vld, busy, done, pen_cnt, a1_cnt
  );
`else
  modport master (
    output start, win, a_in, p0_thr, p1_thr,
    input  b, b_vld, busy, done, pen_cnt, a1_cnt
  );
  modport slave (
    input  start, win, a_in, p0_thr, p1_thr,
    output b, b_vld, busy, done, pen_cnt, a1_cnt
  );
`endif
endinterface

// File: rtl/tsetlin_lfsr16.sv
// 16-bit Galois LFSR used as the environment's random source.
//   clk, rst_n : clock, asynchronous active-low reset (state <= SEED)
//   step_en    : advance one step this edge
//   load       : load seed_val (a zero seed is replaced by SEED); wins over step_en
//   seed_val   : value for load
//   state      : current LFSR value
//   state_next : value after one step (combinational look-ahead)
module tsetlin_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic        load,
  input  logic [15:0] seed_val,
  output logic [15:0] state,
  output logic [15:0] state_next
);
  import tsetlin_pkg::*;

  assign state_next = lfsr_step(state);

  // The all-zero state is a lock-up state for this LFSR, so it is never loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (seed_val == 16'h0000) ? SEED : seed_val;
    end else if (step_en) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/tsetlin_env_feedback.sv
// Stochastic environment feeding the Tsetlin automaton.
// Each RUN cycle samples the action a_in, steps the LFSR and registers the
// feedback b (1 = penalty) as lfsr_next < threshold(a_in). Over a window of
// win samples it counts penalties and action-1 samples, then spends one
// REPORT cycle with done high and the counts published on pen_cnt/a1_cnt.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tsetlin_env_feedback_if slave (start, win, a_in, p0_thr,
//                p1_thr in; b, b_vld, busy, done, pen_cnt, a1_cnt out)
// Optional build macro TSETLIN_FB_SEED_LOAD_EN adds seed_ld/seed_val on the
// bus for reseeding the LFSR while idle.
module tsetlin_env_feedback #(
  parameter int          LFSR_W = 16,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input logic                    clk,
  input logic                    rst_n,
  tsetlin_env_feedback_if.slave  bus
);
  import tsetlin_pkg::*;

  fb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  remain;
  logic [CNT_W-1:0]  pen_live, a1_live;
  logic [CNT_W-1:0]  pen_cnt_q, a1_cnt_q;
  logic              b_p1, vld_p1;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, thr;
  logic              sample, pen_now, seed_load;
  logic [15:0]       seed_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

`ifdef TSETLIN_FB_SEED_LOAD_EN
  assign seed_load = (state == FB_IDLE) && bus.seed_ld;
  assign seed_in   = bus.seed_val;
`else
  assign seed_load = 1'b0;
  assign seed_in   = 16'h0000;
`endif

  // A sample is taken on every RUN edge until the window is exhausted; the
  // final RUN edge (remain == 0) only hands over to REPORT.
  assign sample  = (state == FB_RUN) && (remain != '0);
  assign thr     = bus.a_in ? bus.p1_thr : bus.p0_thr;
  assign pen_now = (lfsr_nxt < thr);

  tsetlin_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_en    (sample),
    .load       (seed_load),
    .seed_val   (seed_in),
    .state      (lfsr_q),
    .state_next (lfsr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FB_IDLE:   if (bus.start) state_nxt = (bus.win != '0) ? FB_RUN : FB_REPORT;
      FB_RUN:    if (remain == '0) state_nxt = FB_REPORT;
      FB_REPORT: state_nxt = FB_IDLE;
      default:   state_nxt = FB_IDLE;
    endcase
  end

  // Stage p1: registered feedback, live statistics and published counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain    <= '0;
      pen_live  <= '0;
      a1_live   <= '0;
      pen_cnt_q <= '0;
      a1_cnt_q  <= '0;
      b_p1      <= FB_REWARD;
      vld_p1    <= 1'b0;
    end else begin
      case (state)
        FB_IDLE: begin
          if (bus.start) begin
            remain   <= bus.win;
            pen_live <= '0;
            a1_live  <= '0;
            // Empty window reports immediately with zero statistics.
            if (bus.win == '0) begin
              pen_cnt_q <= '0;
              a1_cnt_q  <= '0;
            end
          end
        end
        FB_RUN: begin
          if (sample) begin
            b_p1     <= pen_now ? FB_PENALTY : FB_REWARD;
            vld_p1   <= 1'b1;
            pen_live <= sat_inc(pen_live, pen_now);
            a1_live  <= sat_inc(a1_live, bus.a_in);
            remain   <= remain - CNT_W'(1);
          end else begin
            b_p1      <= FB_REWARD;
            vld_p1    <= 1'b0;
            pen_cnt_q <= pen_live;
            a1_cnt_q  <= a1_live;
          end
        end
        default: begin
          b_p1   <= FB_REWARD;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.b       = b_p1;
  assign bus.b_vld   = vld_p1;
  assign bus.busy    = (state != FB_IDLE);
  assign bus.done    = (state == FB_REPORT);
  assign bus.pen_cnt = pen_cnt_q;
  assign bus.a1_cnt  = a1_cnt_q;

endmodule

// File: tb/tb_tsetlin_env_feedback.sv
module tb_tsetlin_env_feedback;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] m_lfsr;   // reference LFSR value (last value used for a sample)
  int   stat_pen;

  tsetlin_env_feedback_if #(.CNT_W(CNT_W)) bus ();

  tsetlin_env_feedback #(.LFSR_W(16), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference step written arithmetically: halve, and fold in the mask when odd.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    if (s % 2 == 1) return (s / 2) ^ 16'hB400;
    return s / 2;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.win = '0; bus.a_in = 1'b0;
    bus.p0_thr = 16'h0; bus.p1_thr = 16'h0;
`ifdef TSETLIN_FB_SEED_LOAD_EN
    bus.seed_ld = 1'b0; bus.seed_val = 16'h0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    @(posedge clk); #1;
  endtask

  // mode: 0 all zero, 1 all one, 2 alternate 0/1, 3 random actions and thresholds
  task automatic run_window(input string tag, input int win, input logic [15:0] p0,
                            input logic [15:0] p1, input int mode, input bit poke,
                            output int pen_res, output int a1_res);
    int pen = 0;
    int a1 = 0;
    logic a;
    logic exp_b;
    logic [15:0] t0, t1;
    t0 = p0; t1 = p1;
    bus.p0_thr = t0; bus.p1_thr = t1;
    bus.win = CNT_W'(win);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.b_vld !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%0b b_vld=%0b done=%0b, required busy=1 b_vld=0 done=0",
               tag, bus.busy, bus.b_vld, bus.done);
    end
    for (int k = 0; k < win; k++) begin
      case (mode)
        0: a = 1'b0;
        1: a = 1'b1;
        2: a = (k % 2 == 1);
        default: begin
          a = $urandom_range(0, 1);
          t0 = 16'($urandom); t1 = 16'($urandom);
          bus.win = CNT_W'($urandom);
        end
      endcase
      bus.a_in = a; bus.p0_thr = t0; bus.p1_thr = t1;
      if (poke && k == win / 2) begin
        bus.start = 1'b1;
`ifdef TSETLIN_FB_SEED_LOAD_EN
        bus.seed_ld = 1'b1; bus.seed_val = 16'h5555;
`endif
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
`ifdef TSETLIN_FB_SEED_LOAD_EN
      bus.seed_ld = 1'b0;
`endif
      m_lfsr = ref_step(m_lfsr);
      exp_b = (m_lfsr < (a ? t1 : t0));
      if (exp_b) pen++;
      if (a) a1++;
      checks++;
      if (bus.b !== exp_b || bus.b_vld !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s sample %0d: b=%0b b_vld=%0b done=%0b busy=%0b, required b=%0b b_vld=1 done=0 busy=1",
                 tag, k, bus.b, bus.b_vld, bus.done, bus.busy, exp_b);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.b !== 1'b0 || bus.b_vld !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s report: done=%0b b=%0b b_vld=%0b busy=%0b, required done=1 b=0 b_vld=0 busy=1",
               tag, bus.done, bus.b, bus.b_vld, bus.busy);
    end
    checks++;
    if (bus.pen_cnt !== CNT_W'(pen) || bus.a1_cnt !== CNT_W'(a1)) begin
      errors++;
      $display("FAIL %s counts: pen_cnt=%0d a1_cnt=%0d, required pen_cnt=%0d a1_cnt=%0d",
               tag, bus.pen_cnt, bus.a1_cnt, pen, a1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pen_cnt !== CNT_W'(pen)) begin
      errors++;
      $display("FAIL %s idle: done=%0b busy=%0b pen_cnt=%0d, required done=0 busy=0 pen_cnt=%0d",
               tag, bus.done, bus.busy, bus.pen_cnt, pen);
    end
    pen_res = pen;
    a1_res = a1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.b, bus.b_vld, bus.busy, bus.done} !== 4'b0 || bus.pen_cnt !== '0 || bus.a1_cnt !== '0) begin
      errors++;
      $display("FAIL reset: b=%0b b_vld=%0b busy=%0b done=%0b pen_cnt=%0d a1_cnt=%0d, required all 0",
               bus.b, bus.b_vld, bus.busy, bus.done, bus.pen_cnt, bus.a1_cnt);
    end
  endtask

  task automatic test_zero_thr();
    int p, q;
    run_window("thr_0_0", 10, 16'h0000, 16'h0000, 3, 1'b0, p, q);
    run_window("thr_0_0b", 10, 16'h0000, 16'h0000, 1, 1'b0, p, q);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL thr_0_0 pen: got %0d, required 0", p);
    end
  endtask

  task automatic test_full_thr();
    int p, q;
    apply_reset();
    run_window("thr_ffff", 10, 16'hFFFF, 16'hFFFF, 1, 1'b0, p, q);
    checks++;
    if (p != 10 || q != 10) begin
      errors++;
      $display("FAIL thr_ffff counts: pen=%0d a1=%0d, required 10 and 10", p, q);
    end
  endtask

  task automatic test_statistical();
    int p, q, p2;
    apply_reset();
    run_window("stat", 1000, 16'h0000, 16'h8000, 1, 1'b0, p, q);
    stat_pen = p;
    checks++;
    if (p < 460 || p > 540 || q != 1000) begin
      errors++;
      $display("FAIL stat range: pen=%0d a1=%0d, required pen 460..540 a1=1000", p, q);
    end
    apply_reset();
    run_window("stat_rerun", 1000, 16'h0000, 16'h8000, 1, 1'b0, p2, q);
    checks++;
    if (p2 != stat_pen) begin
      errors++;
      $display("FAIL stat repeat: pen=%0d, required %0d", p2, stat_pen);
    end
  endtask

  task automatic test_steering();
    int p, q;
    run_window("steer", 8, 16'h0000, 16'hFFFF, 2, 1'b0, p, q);
    checks++;
    if (bus.pen_cnt !== 16'd4 || bus.a1_cnt !== 16'd4) begin
      errors++;
      $display("FAIL steer counts: pen_cnt=%0d a1_cnt=%0d, required 4 and 4", bus.pen_cnt, bus.a1_cnt);
    end
  endtask

  task automatic test_win_zero();
    bus.win = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.b_vld !== 1'b0 ||
        bus.pen_cnt !== '0 || bus.a1_cnt !== '0) begin
      errors++;
      $display("FAIL win0 report: done=%0b busy=%0b b_vld=%0b pen_cnt=%0d a1_cnt=%0d, required 1 1 0 0 0",
               bus.done, bus.busy, bus.b_vld, bus.pen_cnt, bus.a1_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL win0 end: done=%0b busy=%0b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_start_during_run();
    int p, q;
    run_window("start_in_run", 16, 16'h3000, 16'hA000, 3, 1'b1, p, q);
    run_window("after_poke", 6, 16'h7000, 16'h9000, 3, 1'b0, p, q);
  endtask

  task automatic test_reset_mid_run();
    int p, q;
    bit saw_done = 0;
    bus.p0_thr = 16'hFFFF; bus.p1_thr = 16'hFFFF; bus.a_in = 1'b1;
    bus.win = CNT_W'(20);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.b, bus.b_vld, bus.busy, bus.done} !== 4'b0 || bus.pen_cnt !== '0 || bus.a1_cnt !== '0) begin
      errors++;
      $display("FAIL midrun reset: b=%0b b_vld=%0b busy=%0b done=%0b pen_cnt=%0d a1_cnt=%0d, required all 0",
               bus.b, bus.b_vld, bus.busy, bus.done, bus.pen_cnt, bus.a1_cnt);
    end
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst_n = 1'b1;
      if (bus.done !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun no_done: done seen=1, required 0");
    end
    m_lfsr = 16'hACE1;
    run_window("after_reset", 12, 16'h4000, 16'hC000, 3, 1'b0, p, q);
  endtask

`ifdef TSETLIN_FB_SEED_LOAD_EN
  task automatic test_seed_load();
    int p, q;
    run_window("pre_seed", 5, 16'h8000, 16'h8000, 3, 1'b0, p, q);
    bus.seed_val = 16'h0000; bus.seed_ld = 1'b1;
    @(posedge clk); #1;
    bus.seed_ld = 1'b0;
    m_lfsr = 16'hACE1;
    run_window("seed_zero", 10, 16'h6000, 16'hB000, 3, 1'b0, p, q);
    bus.seed_val = 16'h1234; bus.seed_ld = 1'b1;
    @(posedge clk); #1;
    bus.seed_ld = 1'b0;
    m_lfsr = 16'h1234;
    run_window("seed_1234", 20, 16'h6000, 16'hB000, 3, 1'b0, p, q);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_thr();
    test_full_thr();
    test_statistical();
    test_steering();
    test_win_zero();
    test_start_during_run();
    test_reset_mid_run();
`ifdef TSETLIN_FB_SEED_LOAD_EN
    test_seed_load();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
